jtag_master_spw: RTL and testbench

- JTAG TAP master for the SpaceWire node test path: the initiator end of the node's TDI/TDO/TCK scan port.
- Generates TCK from the system clock, drives TMS and TDI, and samples TDO from the node.
- A host issues one command per handshake: TAP reset, IR scan, DR scan, or run-idle clocks. The master sequences the TAP state walk itself and returns the captured TDO bits.
- Between commands the target TAP is always left in Run-Test/Idle.

---
 rtl/jtag_master_spw.sv | 178 +++++++++++++++++
 tb/tb_jtag_master_spw.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master_spw.sv
// JTAG TAP master for the SpaceWire node test port: walks the target TAP through
// reset, IR/DR scans and idle clocks, with TCK divided down from clk.
module jtag_master_spw #(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [5:0]         cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               TCK,
   output logic               TMS,
   output logic               TDI,
   input  logic               TDO
);

   localparam int SW = $clog2(MAX_LEN);
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_IR    = 2'b01;
   localparam logic [1:0] OP_DR    = 2'b10;
   localparam logic [1:0] OP_IDLE  = 2'b11;

   typedef enum logic [2:0] {INIT_RST, IDLE, PRE, SHIFT, POST, DONE} state_t;

   state_t             state, state_nxt, adv_state;
   logic [SW-1:0]      step, step_nxt, adv_step;
   logic [SW-1:0]      last_r, last_nxt;
   logic [7:0]         div_cnt, div_nxt;
   logic [1:0]         op_r, op_nxt;
   logic [MAX_LEN-1:0] data_r, data_nxt, cap_r, cap_nxt, rsp_nxt;
   logic               tck_nxt, tms_nxt, tdi_nxt;
   logic               accept, div_end;

   // Index of the final shift cycle after the 0 -> 1 and >MAX_LEN length rules.
   function automatic logic [SW-1:0] last_idx(input logic [5:0] l);
      if (l == 6'd0)              return '0;
      else if (int'(l) > MAX_LEN) return SW'(MAX_LEN - 1);
      else                        return SW'(int'(l) - 1);
   endfunction

   function automatic logic [SW-1:0] pre_last(input logic [1:0] op);
      case (op)
         OP_RESET: return SW'(5);
         OP_IR:    return SW'(3);
         OP_DR:    return SW'(2);
         default:  return '0;
      endcase
   endfunction

   // TMS driven during a given TCK cycle of the walk.
   function automatic logic walk_tms(input state_t st, input logic [SW-1:0] stp,
                                     input logic [1:0] op, input logic [SW-1:0] last);
      case (st)
         INIT_RST: return stp < SW'(5);
         PRE: begin
            case (op)
               OP_RESET: return stp < SW'(5);
               OP_IR:    return stp < SW'(2);
               OP_DR:    return stp == '0;
               default:  return 1'b0;
            endcase
         end
         SHIFT:   return (op != OP_IDLE) && (stp == last);
         POST:    return stp == '0;
         default: return 1'b0;
      endcase
   endfunction

   assign cmd_ready = (state == IDLE) || (state == DONE);
   assign rsp_valid = (state == DONE);
   assign accept    = cmd_valid && cmd_ready;
   assign div_end   = (div_cnt == DIV_LAST);

   // Where the walk goes once the current TCK cycle ends.
   always_comb begin
      adv_state = state;
      adv_step  = step + SW'(1);
      case (state)
         INIT_RST: if (step == SW'(5)) begin
            adv_state = IDLE;
            adv_step  = '0;
         end
         PRE: if (step == pre_last(op_r)) begin
            adv_state = (op_r == OP_RESET) ? DONE : SHIFT;
            adv_step  = '0;
         end
         SHIFT: if (step == last_r) begin
            adv_state = (op_r == OP_IDLE) ? DONE : POST;
            adv_step  = '0;
         end
         POST: if (step == SW'(1)) begin
            adv_state = DONE;
            adv_step  = '0;
         end
         default: ;
      endcase
   end

   // NOTE: every signal gets its default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      div_nxt   = div_cnt;
      tck_nxt   = TCK;
      tms_nxt   = TMS;
      tdi_nxt   = TDI;
      op_nxt    = op_r;
      last_nxt  = last_r;
      data_nxt  = data_r;
      cap_nxt   = cap_r;
      rsp_nxt   = rsp_data;
      if (accept) begin
         op_nxt    = cmd_op;
         last_nxt  = last_idx(cmd_len);
         data_nxt  = cmd_data;
         cap_nxt   = '0;
         state_nxt = (cmd_op == OP_IDLE) ? SHIFT : PRE;
         step_nxt  = '0;
         div_nxt   = '0;
         tck_nxt   = 1'b0;
         tms_nxt   = walk_tms((cmd_op == OP_IDLE) ? SHIFT : PRE, '0, cmd_op, last_idx(cmd_len));
         tdi_nxt   = 1'b0;
      end else if (state inside {INIT_RST, PRE, SHIFT, POST}) begin
         div_nxt = div_end ? 8'd0 : div_cnt + 8'd1;
         if (div_end && !TCK) begin
            tck_nxt = 1'b1;
            if (state == SHIFT && (op_r == OP_IR || op_r == OP_DR))
               cap_nxt[step] = TDO;
         end else if (div_end) begin
            tck_nxt   = 1'b0;
            state_nxt = adv_state;
            step_nxt  = adv_step;
            tms_nxt   = walk_tms(adv_state, adv_step, op_r, last_r);
            tdi_nxt   = (adv_state == SHIFT && op_r != OP_IDLE) ? data_r[adv_step] : 1'b0;
            if (adv_state == DONE)
               rsp_nxt = cap_r;
         end
      end else if (state == DONE) begin
         state_nxt = IDLE;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= INIT_RST;
         step     <= '0;
         div_cnt  <= '0;
         TCK      <= 1'b0;
         TMS      <= 1'b1;
         TDI      <= 1'b0;
         op_r     <= OP_RESET;
         last_r   <= '0;
         data_r   <= '0;
         cap_r    <= '0;
         rsp_data <= '0;
      end else begin
         state    <= state_nxt;
         step     <= step_nxt;
         div_cnt  <= div_nxt;
         TCK      <= tck_nxt;
         TMS      <= tms_nxt;
         TDI      <= tdi_nxt;
         op_r     <= op_nxt;
         last_r   <= last_nxt;
         data_r   <= data_nxt;
         cap_r    <= cap_nxt;
         rsp_data <= rsp_nxt;
      end
   end

endmodule

// File: tb/tb_jtag_master_spw.sv
// Scoreboard bench for jtag_master_spw: a behavioural TAP target on the scan port,
// expected TMS/TDI/TDO traces built from the TAP walk rules, checked per response.
module tb_jtag_master_spw;

   localparam int CLK_DIV = 2;
   localparam int MAX_LEN = 32;
   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_IR    = 2'b01;
   localparam logic [1:0] OP_DR    = 2'b10;
   localparam logic [1:0] OP_IDLE  = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [5:0]  cmd_len = 6'd0;
   logic [31:0] cmd_data = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        TCK, TMS, TDI, TDO;

   jtag_master_spw #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
   );

   always #5 clk = ~clk;

   // Target TAP: IR captures 1, DR is a straight TDI->TDO loopback.
   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PAU_DR, T_EX2_DR, T_UPD_DR,
      T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PAU_IR, T_EX2_IR, T_UPD_IR
   } tap_t;

   tap_t        tap = T_SH_DR;
   logic [31:0] ir_sr = 32'd0;
   int          shift_total = 0;

   function automatic tap_t tap_next(input tap_t s, input logic m);
      case (s)
         T_TLR:    return m ? T_TLR    : T_RTI;
         T_RTI:    return m ? T_SEL_DR : T_RTI;
         T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
         T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
         T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
         T_EX1_DR: return m ? T_UPD_DR : T_PAU_DR;
         T_PAU_DR: return m ? T_EX2_DR : T_PAU_DR;
         T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
         T_UPD_DR: return m ? T_SEL_DR : T_RTI;
         T_SEL_IR: return m ? T_TLR    : T_CAP_IR;
         T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
         T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
         T_EX1_IR: return m ? T_UPD_IR : T_PAU_IR;
         T_PAU_IR: return m ? T_EX2_IR : T_PAU_IR;
         T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
         default:  return m ? T_SEL_DR : T_RTI;
      endcase
   endfunction

   always @(posedge TCK) begin
      if (tap == T_CAP_IR)     ir_sr <= 32'h1;
      else if (tap == T_SH_IR) ir_sr <= {TDI, ir_sr[31:1]};
      if (tap == T_SH_DR || tap == T_SH_IR) shift_total <= shift_total + 1;
      tap <= tap_next(tap, TMS);
   end

   assign TDO = (tap == T_SH_DR) ? TDI : (tap == T_SH_IR) ? ir_sr[0] : 1'b0;

   typedef struct {
      int          n;
      logic [63:0] tms;
      logic [63:0] tdi;
      logic [31:0] rsp;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0, n_fail = 0, n_sent = 0, n_acc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected TCK-by-TCK trace of one command, straight from the TAP walk lists.
   function automatic exp_t model(input logic [1:0] op, input int len, input logic [31:0] data);
      exp_t        e;
      int          n = 0;
      int          l = (len == 0) ? 1 : (len > MAX_LEN) ? MAX_LEN : len;
      logic [3:0]  pre;
      int          pn;
      e.tms = '0; e.tdi = '0; e.rsp = '0;
      if (op == OP_RESET) begin
         for (int i = 0; i < 6; i++) begin e.tms[n] = (i < 5); n++; end
      end else if (op == OP_IDLE) begin
         n = l;
      end else begin
         pre = (op == OP_IR) ? 4'b0011 : 4'b0001;
         pn  = (op == OP_IR) ? 4 : 3;
         for (int i = 0; i < pn; i++) begin e.tms[n] = pre[i]; n++; end
         for (int i = 0; i < l; i++) begin
            e.tms[n] = (i == l - 1);
            e.tdi[n] = data[i];
            n++;
         end
         e.tms[n] = 1'b1; n++;
         e.tms[n] = 1'b0; n++;
         e.rsp = (op == OP_IR) ? 32'h1 : 32'(64'(data) & ((64'd1 << l) - 64'd1));
      end
      e.n = n;
      return e;
   endfunction

   // Monitor: logs TMS/TDI at each TCK rise and checks every response against the scoreboard.
   int          tck_cnt = 0, cyc_cnt = 0;
   logic [63:0] tms_log = '0, tdi_log = '0;
   logic        tck_prev = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            tck_cnt = 0; cyc_cnt = 0; tms_log = '0; tdi_log = '0;
         end else begin
            if (rsp_valid) begin
               if (sb.size() == 0) check("unexpected_rsp", 1, 0);
               else begin
                  e = sb.pop_front();
                  check("rsp_data", rsp_data, e.rsp);
                  check("tck_count", tck_cnt, e.n);
                  check("clk_count", cyc_cnt, e.n * 2 * CLK_DIV);
                  check("tms_trace", tms_log, e.tms);
                  check("tdi_trace", tdi_log, e.tdi);
                  check("tap_in_idle", 64'(tap), 64'(T_RTI));
               end
            end
            if (TCK && !tck_prev) begin
               if (tck_cnt < 64) begin tms_log[tck_cnt] = TMS; tdi_log[tck_cnt] = TDI; end
               tck_cnt++;
            end
            if (cmd_valid && cmd_ready) begin
               n_acc++; tck_cnt = 0; cyc_cnt = 0; tms_log = '0; tdi_log = '0;
            end else cyc_cnt++;
         end
         tck_prev = TCK;
      end
   end

   task automatic step_clk();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [1:0] op, input int len, input logic [31:0] data,
                       input bit in_done);
      int w = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_len = 6'(len); cmd_data = data;
      while (!cmd_ready && w < 400) begin step_clk(); w++; end
      if (!cmd_ready) begin
         check("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      if (in_done) check("b2b_accept_in_done", rsp_valid, 1);
      sb.push_back(model(op, len, data));
      n_sent++;
      step_clk();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      while ((sb.size() != 0 || !cmd_ready) && w < 1000) begin step_clk(); w++; end
      if (w >= 1000) check("idle_timeout", 0, 1);
   endtask

   task automatic powerup();
      int n = 0;
      reset = 1'b1;
      repeat (3) step_clk();
      check("rst_tck", TCK, 0);
      check("rst_tms", TMS, 1);
      check("rst_tdi", TDI, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      reset = 1'b0;
      while (!cmd_ready && n < 200) begin step_clk(); n++; end
      check("init_ready_delay", n, 12 * CLK_DIV);
      check("init_tck_count", tck_cnt, 6);
      check("init_tms_trace", tms_log, 64'h1F);
      check("init_tap_idle", 64'(tap), 64'(T_RTI));
   endtask

   initial begin
      int base;
      int w;
      step_clk();
      powerup();

      send(OP_DR, 8, 32'hA5, 0);          wait_idle();
      send(OP_IR, 4, 32'h3, 0);           wait_idle();
      send(OP_DR, 0, 32'hFFFF_FFFF, 0);   wait_idle();
      send(OP_DR, 40, $urandom, 0);       wait_idle();
      send(OP_IDLE, 5, 32'hFFFF_FFFF, 0); wait_idle();
      send(OP_RESET, 3, 32'h5A5A_5A5A, 0); wait_idle();

      // cmd_valid held through busy periods; each follow-on lands in the DONE cycle.
      send(OP_DR, 6, $urandom, 0);
      send(OP_IR, 5, $urandom, 1);
      send(OP_IDLE, 3, $urandom, 1);
      wait_idle();

      for (int i = 0; i < 30; i++) begin
         send(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom, 0);
         repeat ($urandom_range(0, 3)) step_clk();
      end
      wait_idle();

      // Abort a 16-bit DR scan during its fourth shift bit.
      base = shift_total;
      send(OP_DR, 16, $urandom, 0);
      w = 0;
      while (shift_total < base + 3 && w < 500) begin step_clk(); w++; end
      check("abort_reached_bit3", shift_total - base, 3);
      repeat (CLK_DIV + 1) step_clk();
      reset = 1'b1;
      sb.delete();
      step_clk();
      check("abort_tck", TCK, 0);
      check("abort_tms", TMS, 1);
      check("abort_rsp_valid", rsp_valid, 0);
      powerup();

      send(OP_DR, 12, $urandom, 0); wait_idle();

      check("accept_count", n_acc, n_sent);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
